// File: rtl/riscv_v_bypass_net.sv
// Vector operand bypass network with retired-write history and a
// long-latency scoreboard. Each operand byte is taken from the youngest
// in-flight stage writing that byte, else from the newest retired write
// still in the history window, else from the register file.
module riscv_v_bypass_net #(
   parameter int DATA_W     = 128,
   parameter int NUM_SRC    = 3,
   parameter int NUM_STG    = 2,
   parameter int HIST_DEPTH = 2,
   parameter int AW         = 5
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic [NUM_STG-1:0]              wr_vld,
   input  logic [NUM_STG*AW-1:0]           wr_addr,
   input  logic [NUM_STG*(DATA_W/8)-1:0]   wr_be,
   input  logic [NUM_STG*DATA_W-1:0]       wr_data,
   input  logic [NUM_SRC-1:0]              src_vld,
   input  logic [NUM_SRC*AW-1:0]           src_addr,
   input  logic [NUM_SRC*DATA_W-1:0]       src_rf,
   output logic [NUM_SRC*DATA_W-1:0]       src_byp,
   input  logic                            lng_iss_vld,
   input  logic [AW-1:0]                   lng_iss_addr,
   input  logic                            lng_done_vld,
   input  logic [AW-1:0]                   lng_done_addr,
   output logic                            stall,
   output logic [(1<<AW)-1:0]              pend
);

   localparam int NB = DATA_W / 8;

   // Retired-write history; entry 0 is the most recent retirement.
   logic              hist_vld  [HIST_DEPTH];
   logic [AW-1:0]     hist_addr [HIST_DEPTH];
   logic [NB-1:0]     hist_be   [HIST_DEPTH];
   logic [DATA_W-1:0] hist_data [HIST_DEPTH];

   // History valid bits: shift in the WB stage, cleared by reset or flush.
   // NOTE: sequential state is written with <= so every flop samples the
   // pre-edge values; = here would collapse the shift chain into one stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < HIST_DEPTH; i++) hist_vld[i] <= 1'b0;
      end else if (flush) begin
         for (int i = 0; i < HIST_DEPTH; i++) hist_vld[i] <= 1'b0;
      end else begin
         hist_vld[0] <= wr_vld[NUM_STG-1];
         for (int i = 1; i < HIST_DEPTH; i++) hist_vld[i] <= hist_vld[i-1];
      end
   end

   // History payload: shift unconditionally alongside the valid bits.
   // NOTE: payload storage is deliberately not reset; an entry is only ever
   // consulted when its valid bit is set, so reset fan-out to the wide data
   // array buys nothing.
   always_ff @(posedge clk) begin
      hist_addr[0] <= wr_addr[(NUM_STG-1)*AW +: AW];
      hist_be[0]   <= wr_be[(NUM_STG-1)*NB +: NB];
      hist_data[0] <= wr_data[(NUM_STG-1)*DATA_W +: DATA_W];
      for (int i = 1; i < HIST_DEPTH; i++) begin
         hist_addr[i] <= hist_addr[i-1];
         hist_be[i]   <= hist_be[i-1];
         hist_data[i] <= hist_data[i-1];
      end
   end

   // Per-byte operand select; later assignments override earlier ones, so
   // sources are visited from lowest to highest priority.
   // NOTE: the output gets a full default before any conditional override,
   // which keeps this block purely combinational with no inferred latch.
   always_comb begin
      src_byp = src_rf;
      for (int c = 0; c < NUM_SRC; c++) begin
         for (int b = 0; b < NB; b++) begin
            for (int h = HIST_DEPTH-1; h >= 0; h--) begin
               if (hist_vld[h] && hist_be[h][b] &&
                   hist_addr[h] == src_addr[c*AW +: AW])
                  src_byp[c*DATA_W + b*8 +: 8] = hist_data[h][b*8 +: 8];
            end
            for (int s = NUM_STG-1; s >= 0; s--) begin
               if (wr_vld[s] && wr_be[s*NB + b] &&
                   wr_addr[s*AW +: AW] == src_addr[c*AW +: AW])
                  src_byp[c*DATA_W + b*8 +: 8] = wr_data[s*DATA_W + b*8 +: 8];
            end
         end
      end
   end

   // Scoreboard: issue sets, completion clears, set wins, flush clears all.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= '0;
      end else if (flush) begin
         pend <= '0;
      end else begin
         if (lng_done_vld) pend[lng_done_addr] <= 1'b0;
         if (lng_iss_vld)  pend[lng_iss_addr]  <= 1'b1;
      end
   end

   // Stall whenever a live read targets a register still being produced.
   always_comb begin
      stall = 1'b0;
      for (int c = 0; c < NUM_SRC; c++)
         stall = stall | (src_vld[c] & pend[src_addr[c*AW +: AW]]);
   end

endmodule

// File: tb/tb_riscv_v_bypass_net.sv
// Self-checking bench for riscv_v_bypass_net: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_riscv_v_bypass_net;

   localparam int DATA_W     = 128;
   localparam int NUM_SRC    = 3;
   localparam int NUM_STG    = 2;
   localparam int HIST_DEPTH = 2;
   localparam int AW         = 5;
   localparam int NB         = DATA_W / 8;
   localparam int NREG       = 1 << AW;

   logic                          clk;
   logic                          rst;
   logic                          flush;
   logic [NUM_STG-1:0]            wr_vld;
   logic [NUM_STG*AW-1:0]         wr_addr;
   logic [NUM_STG*NB-1:0]         wr_be;
   logic [NUM_STG*DATA_W-1:0]     wr_data;
   logic [NUM_SRC-1:0]            src_vld;
   logic [NUM_SRC*AW-1:0]         src_addr;
   logic [NUM_SRC*DATA_W-1:0]     src_rf;
   logic [NUM_SRC*DATA_W-1:0]     src_byp;
   logic                          lng_iss_vld;
   logic [AW-1:0]                 lng_iss_addr;
   logic                          lng_done_vld;
   logic [AW-1:0]                 lng_done_addr;
   logic                          stall;
   logic [NREG-1:0]               pend;

   int checks   = 0;
   int failures = 0;

   riscv_v_bypass_net #(
      .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG),
      .HIST_DEPTH(HIST_DEPTH), .AW(AW)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
      .src_vld(src_vld), .src_addr(src_addr), .src_rf(src_rf), .src_byp(src_byp),
      .lng_iss_vld(lng_iss_vld), .lng_iss_addr(lng_iss_addr),
      .lng_done_vld(lng_done_vld), .lng_done_addr(lng_done_addr),
      .stall(stall), .pend(pend)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   typedef struct {
      bit                vld;
      logic [AW-1:0]     addr;
      logic [NB-1:0]     be;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t             hq[$];   // retired writes, newest first
   logic [NREG-1:0] m_pend;

   function automatic logic [DATA_W-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Expected operand for channel c from the current inputs and model state.
   function automatic logic [DATA_W-1:0] exp_byp(int c);
      logic [DATA_W-1:0] r;
      logic [AW-1:0]     a;
      a = src_addr[c*AW +: AW];
      r = src_rf[c*DATA_W +: DATA_W];
      for (int b = 0; b < NB; b++) begin : per_byte
         bit found;
         found = 0;
         for (int s = 0; s < NUM_STG && !found; s++)
            if (wr_vld[s] && wr_be[s*NB+b] && wr_addr[s*AW +: AW] == a) begin
               r[b*8 +: 8] = wr_data[s*DATA_W + b*8 +: 8];
               found = 1;
            end
         for (int h = 0; h < hq.size() && !found; h++)
            if (hq[h].vld && hq[h].be[b] && hq[h].addr == a) begin
               r[b*8 +: 8] = hq[h].data[b*8 +: 8];
               found = 1;
            end
      end
      return r;
   endfunction

   function automatic logic exp_stall();
      logic st;
      st = 1'b0;
      for (int c = 0; c < NUM_SRC; c++)
         if (src_vld[c] && m_pend[src_addr[c*AW +: AW]]) st = 1'b1;
      return st;
   endfunction

   // Advance one clock edge and update the model with the inputs it saw.
   task automatic tick();
      wr_t e;
      @(posedge clk);
      if (rst) begin
         hq.delete();
         m_pend = '0;
      end else begin
         e.vld  = wr_vld[NUM_STG-1] && !flush;
         e.addr = wr_addr[(NUM_STG-1)*AW +: AW];
         e.be   = wr_be[(NUM_STG-1)*NB +: NB];
         e.data = wr_data[(NUM_STG-1)*DATA_W +: DATA_W];
         if (flush) foreach (hq[i]) hq[i].vld = 0;
         hq.push_front(e);
         if (hq.size() > HIST_DEPTH) hq.delete(HIST_DEPTH);
         if (flush) m_pend = '0;
         else begin
            if (lng_done_vld) m_pend[lng_done_addr] = 1'b0;
            if (lng_iss_vld)  m_pend[lng_iss_addr]  = 1'b1;
         end
      end
      #1;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      flush = 0; wr_vld = '0; wr_addr = '0; wr_be = '0; wr_data = '0;
      src_vld = '0; src_addr = '0;
      src_rf = {rnd_data(), rnd_data(), rnd_data()};
      lng_iss_vld = 0; lng_iss_addr = '0; lng_done_vld = 0; lng_done_addr = '0;
   endtask

   task automatic set_stage(int s, logic v, logic [AW-1:0] a, logic [NB-1:0] be,
                            logic [DATA_W-1:0] d);
      wr_vld[s] = v;
      wr_addr[s*AW +: AW] = a;
      wr_be[s*NB +: NB] = be;
      wr_data[s*DATA_W +: DATA_W] = d;
   endtask

   task automatic set_src(int c, logic v, logic [AW-1:0] a);
      src_vld[c] = v;
      src_addr[c*AW +: AW] = a;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [DATA_W-1:0] x;
      rst = 1; idle();
      x = rnd_data();
      set_stage(0, 1, 5'd2, '1, x);
      set_src(0, 1, 5'd2);
      set_src(1, 1, 5'd9);
      @(negedge clk);
      checks++;
      if (pend !== '0) begin failures++; $display("FAIL reset_pend got=%h exp=0", pend); end
      checks++;
      if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
      checks++;
      if (src_byp[0 +: DATA_W] !== x) begin
         failures++; $display("FAIL reset_stage_byp got=%h exp=%h", src_byp[0 +: DATA_W], x);
      end
      checks++;
      if (src_byp[DATA_W +: DATA_W] !== src_rf[DATA_W +: DATA_W]) begin
         failures++; $display("FAIL reset_rf got=%h exp=%h", src_byp[DATA_W +: DATA_W], src_rf[DATA_W +: DATA_W]);
      end
      tick(); tick();
      rst = 0; idle();
      tick();
   endtask

   task automatic test_stage_priority();
      logic [DATA_W-1:0] a, b, exp;
      idle();
      a = rnd_data(); b = rnd_data();
      set_stage(0, 1, 5'd3, '1, a);
      set_stage(1, 1, 5'd3, '1, b);
      set_src(0, 1, 5'd3);
      @(negedge clk);
      checks++;
      if (src_byp[0 +: DATA_W] !== a) begin
         failures++; $display("FAIL stage_priority got=%h exp=%h", src_byp[0 +: DATA_W], a);
      end
      tick();
      // partial byte enables on stage 0: low 8 bytes from A, high from B
      idle();
      a = rnd_data(); b = rnd_data();
      set_stage(0, 1, 5'd3, 16'h00FF, a);
      set_stage(1, 1, 5'd3, '1, b);
      set_src(2, 1, 5'd3);
      exp = {b[127:64], a[63:0]};
      @(negedge clk);
      checks++;
      if (src_byp[2*DATA_W +: DATA_W] !== exp) begin
         failures++; $display("FAIL byte_merge got=%h exp=%h", src_byp[2*DATA_W +: DATA_W], exp);
      end
      tick();
      // flush history written above so later directed tests start clean
      idle(); flush = 1; tick();
   endtask

   task automatic test_history();
      logic [DATA_W-1:0] c_val;
      idle();
      c_val = rnd_data();
      set_stage(1, 1, 5'd5, '1, c_val);
      set_src(0, 1, 5'd5);
      @(negedge clk);
      checks++;
      if (src_byp[0 +: DATA_W] !== c_val) begin
         failures++; $display("FAIL hist_wb got=%h exp=%h", src_byp[0 +: DATA_W], c_val);
      end
      tick();
      for (int k = 1; k <= HIST_DEPTH + 1; k++) begin
         idle();
         set_src(0, 1, 5'd5);
         @(negedge clk);
         checks++;
         if (k <= HIST_DEPTH) begin
            if (src_byp[0 +: DATA_W] !== c_val) begin
               failures++; $display("FAIL hist_hit_%0d got=%h exp=%h", k, src_byp[0 +: DATA_W], c_val);
            end
         end else if (src_byp[0 +: DATA_W] !== src_rf[0 +: DATA_W]) begin
            failures++; $display("FAIL hist_expire got=%h exp=%h", src_byp[0 +: DATA_W], src_rf[0 +: DATA_W]);
         end
         tick();
      end
   endtask

   task automatic test_scoreboard();
      idle();
      lng_iss_vld = 1; lng_iss_addr = 5'd7;
      set_src(1, 1, 5'd7);
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin failures++; $display("FAIL sb_iss_same_cycle got=%b exp=0", stall); end
      tick();
      idle();
      set_src(1, 1, 5'd7);
      set_src(0, 0, 5'd7);
      lng_done_vld = 1; lng_done_addr = 5'd7;
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || pend[7] !== 1'b1) begin
         failures++; $display("FAIL sb_stall got=%b/%b exp=1/1", stall, pend[7]);
      end
      tick();
      idle();
      set_src(1, 1, 5'd7);
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || pend !== '0) begin
         failures++; $display("FAIL sb_done got=%b pend=%h exp=0", stall, pend);
      end
      // invalid channel reading a pending register must not stall
      lng_iss_vld = 1; lng_iss_addr = 5'd7;
      tick();
      idle();
      set_src(2, 0, 5'd7);
      lng_iss_vld = 1; lng_iss_addr = 5'd7;
      lng_done_vld = 1; lng_done_addr = 5'd7;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin failures++; $display("FAIL sb_invalid_chan got=%b exp=0", stall); end
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (pend[7] !== 1'b1) begin failures++; $display("FAIL sb_set_wins got=%b exp=1", pend[7]); end
      lng_done_vld = 1; lng_done_addr = 5'd7;
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (pend !== '0) begin failures++; $display("FAIL sb_clear got=%h exp=0", pend); end
      tick();
   endtask

   task automatic test_flush_and_async_reset();
      logic [DATA_W-1:0] d;
      idle();
      d = rnd_data();
      lng_iss_vld = 1; lng_iss_addr = 5'd4;
      set_stage(1, 1, 5'd9, '1, d);
      tick();
      idle();
      set_src(0, 1, 5'd9);
      set_src(1, 1, 5'd4);
      flush = 1;
      lng_iss_vld = 1; lng_iss_addr = 5'd6;
      @(negedge clk);
      checks++;
      if (pend[4] !== 1'b1 || stall !== 1'b1 || src_byp[0 +: DATA_W] !== d) begin
         failures++; $display("FAIL flush_pre pend4=%b stall=%b byp=%h exp=1/1/%h", pend[4], stall, src_byp[0 +: DATA_W], d);
      end
      tick();
      idle();
      set_src(0, 1, 5'd9);
      set_src(1, 1, 5'd4);
      @(negedge clk);
      checks++;
      if (pend !== '0 || stall !== 1'b0 || src_byp[0 +: DATA_W] !== src_rf[0 +: DATA_W]) begin
         failures++; $display("FAIL flush_post pend=%h stall=%b byp=%h exp=0/0/%h", pend, stall, src_byp[0 +: DATA_W], src_rf[0 +: DATA_W]);
      end
      // async reset between edges
      lng_iss_vld = 1; lng_iss_addr = 5'd4;
      tick();
      idle();
      set_src(1, 1, 5'd4);
      #1;
      checks++;
      if (pend[4] !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b exp=1", pend[4]); end
      #1 rst = 1;
      hq.delete(); m_pend = '0;
      #1;
      checks++;
      if (pend !== '0 || stall !== 1'b0) begin
         failures++; $display("FAIL arst_immediate pend=%h stall=%b exp=0/0", pend, stall);
      end
      #1 rst = 0;
      tick();
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] e;
      for (int n = 0; n < 400; n++) begin
         idle();
         for (int s = 0; s < NUM_STG; s++)
            set_stage(s, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0) ? '1 : NB'($urandom), rnd_data());
         for (int c = 0; c < NUM_SRC; c++)
            set_src(c, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
         lng_iss_vld   = ($urandom_range(0, 3) == 0);
         lng_iss_addr  = 5'($urandom_range(0, 7));
         lng_done_vld  = ($urandom_range(0, 2) == 0);
         lng_done_addr = 5'($urandom_range(0, 7));
         flush         = ($urandom_range(0, 31) == 0);
         @(negedge clk);
         for (int c = 0; c < NUM_SRC; c++) begin
            e = exp_byp(c);
            checks++;
            if (src_byp[c*DATA_W +: DATA_W] !== e) begin
               failures++;
               $display("FAIL rnd_byp cyc=%0d ch=%0d got=%h exp=%h", n, c, src_byp[c*DATA_W +: DATA_W], e);
            end
         end
         checks++;
         if (stall !== exp_stall()) begin
            failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", n, stall, exp_stall());
         end
         checks++;
         if (pend !== m_pend) begin
            failures++; $display("FAIL rnd_pend cyc=%0d got=%h exp=%h", n, pend, m_pend);
         end
         tick();
      end
   endtask

   initial begin
      m_pend = '0;
      test_reset();
      test_stage_priority();
      test_history();
      test_scoreboard();
      test_flush_and_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
